// File: rtl/vacc_pkg.sv
// vacc_pkg: shared FSM encoding and saturation limits for the vector accumulator
package vacc_pkg;

    typedef enum logic [1:0] {
        S_IDLE,
        S_FIRST,
        S_ACC
    } state_t;

    // Two's-complement clamp value for a given width: most negative when neg=1, else most positive
    function automatic logic [63:0] sat_limit(input int width, input logic neg);
        logic [63:0] pos;
        pos = (64'd1 << (width - 1)) - 64'd1;
        return neg ? ~pos : pos;
    endfunction

endpackage

// File: rtl/parallel_vector_acc_if.sv
// parallel_vector_acc_if: sample stream in, accumulated vector stream out
interface parallel_vector_acc_if #(
    parameter int DIN_WIDTH     = 16,
    parameter int DOUT_WIDTH    = 32,
    parameter int LANES         = 4,
    parameter int ACC_LEN_WIDTH = 16
);
    logic                          sync;
    logic [ACC_LEN_WIDTH-1:0]      acc_len;
    logic [LANES*DIN_WIDTH-1:0]    din;
    logic                          din_valid;
    logic [LANES*DOUT_WIDTH-1:0]   dout;
    logic                          dout_valid;
    logic                          dout_last;
    logic [LANES-1:0]              dout_ovf;

    modport master (output sync, acc_len, din, din_valid, input dout, dout_valid, dout_last, dout_ovf);
    modport slave  (input sync, acc_len, din, din_valid, output dout, dout_valid, dout_last, dout_ovf);
endinterface

// File: rtl/bram_infer.sv
// bram_infer: simple dual-port RAM, one write port, registered read port
module bram_infer #(
    parameter int ADDR_WIDTH = 6,
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  i_we,
    input  logic [ADDR_WIDTH-1:0] i_waddr,
    input  logic [DATA_WIDTH-1:0] i_wdata,
    input  logic [ADDR_WIDTH-1:0] i_raddr,
    output logic [DATA_WIDTH-1:0] o_rdata
);
    logic [DATA_WIDTH-1:0] r_mem [2**ADDR_WIDTH];

    // Write port
    always_ff @(posedge clk) begin
        if (i_we) r_mem[i_waddr] <= i_wdata;
    end

    // Registered read port
    always_ff @(posedge clk) begin
        o_rdata <= r_mem[i_raddr];
    end
endmodule

// File: rtl/sat_add_lane.sv
// sat_add_lane: one lane's accumulate step with saturate-or-wrap and sticky overflow
module sat_add_lane
    import vacc_pkg::*;
#(
    parameter int DIN_WIDTH  = 16,
    parameter int DOUT_WIDTH = 32,
    parameter int SATURATE   = 1
) (
    input  logic                         i_first,
    input  logic signed [DOUT_WIDTH-1:0] i_acc,
    input  logic                         i_ovf,
    input  logic signed [DIN_WIDTH-1:0]  i_din,
    output logic signed [DOUT_WIDTH-1:0] o_sum,
    output logic                         o_ovf
);
    logic [DOUT_WIDTH:0] w_acc, w_din, w_full;
    logic                w_ovf;

    // One guard bit catches overflow; the first frame adds to zero so it never overflows
    assign w_acc  = i_first ? '0 : {i_acc[DOUT_WIDTH-1], i_acc};
    assign w_din  = (DOUT_WIDTH+1)'(i_din);
    assign w_full = w_acc + w_din;
    assign w_ovf  = w_full[DOUT_WIDTH] ^ w_full[DOUT_WIDTH-1];
    assign o_sum  = (w_ovf && SATURATE != 0) ? DOUT_WIDTH'(sat_limit(DOUT_WIDTH, w_full[DOUT_WIDTH]))
                                             : w_full[DOUT_WIDTH-1:0];
    assign o_ovf  = w_ovf | (~i_first & i_ovf);
endmodule

// File: rtl/parallel_vector_acc.sv
// parallel_vector_acc: multi-lane vector accumulator over acc_len frames with fixed 2-cycle latency
module parallel_vector_acc
    import vacc_pkg::*;
#(
    parameter int DIN_WIDTH     = 16,
    parameter int DOUT_WIDTH    = 32,
    parameter int LANES         = 4,
    parameter int VECTOR_LEN    = 64,
    parameter int ACC_LEN_WIDTH = 16,
    parameter int SATURATE      = 1
) (
    input logic                 clk,
    input logic                 rst_n,
    parallel_vector_acc_if.slave bus
);
    localparam int AW = $clog2(VECTOR_LEN);
    localparam int LW = DOUT_WIDTH + 1;

    state_t                     r_state;
    logic [AW-1:0]              r_addr;
    logic [ACC_LEN_WIDTH-1:0]   r_frame, r_len;

    logic                       r1_valid, r1_first, r1_out, r1_last;
    logic [AW-1:0]              r1_addr;
    logic [LANES*DIN_WIDTH-1:0] r1_din;

    logic                       r2_valid, r2_last;
    logic [LANES*DOUT_WIDTH-1:0] r2_sum;
    logic [LANES-1:0]           r2_ovf;

    logic                       w_sync, w_act, w_first, w_out, w_wrap;
    logic [AW-1:0]              w_addr;
    logic [ACC_LEN_WIDTH-1:0]   w_len_in, w_len, w_frame;
    logic [LANES*LW-1:0]        w_rd, w_wr;
    logic [LANES*DOUT_WIDTH-1:0] w_sum;
    logic [LANES-1:0]           w_ovf;

    // A qualified sync makes this very sample element 0 of frame 0 with a freshly latched length
    assign w_sync   = bus.sync & bus.din_valid;
    assign w_len_in = (bus.acc_len == '0) ? ACC_LEN_WIDTH'(1) : bus.acc_len;
    assign w_act    = bus.din_valid & (w_sync | (r_state != S_IDLE));
    assign w_addr   = w_sync ? '0 : r_addr;
    assign w_frame  = w_sync ? '0 : r_frame;
    assign w_len    = w_sync ? w_len_in : r_len;
    assign w_first  = w_sync | (r_state == S_FIRST);
    assign w_out    = w_frame == w_len - 1'b1;
    assign w_wrap   = w_addr == AW'(VECTOR_LEN - 1);

    // Element/frame sequencing; acc_len is only sampled at sync or when the last frame wraps
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_addr  <= '0;
            r_frame <= '0;
            r_len   <= ACC_LEN_WIDTH'(1);
        end else if (w_act) begin
            r_addr  <= w_addr + 1'b1;
            r_frame <= w_wrap ? (w_out ? '0 : w_frame + 1'b1) : w_frame;
            r_len   <= (w_wrap && w_out) ? w_len_in : w_len;
            r_state <= w_wrap ? (w_out ? S_FIRST : S_ACC) : (w_sync ? S_FIRST : r_state);
        end
    end

    // Stage 1: hold the sample while the RAM returns the running sum for its element
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r1_valid <= 1'b0;
            r1_first <= 1'b0;
            r1_out   <= 1'b0;
            r1_last  <= 1'b0;
            r1_addr  <= '0;
            r1_din   <= '0;
        end else begin
            r1_valid <= w_act;
            if (w_act) begin
                r1_first <= w_first;
                r1_out   <= w_out;
                r1_last  <= w_wrap;
                r1_addr  <= w_addr;
                r1_din   <= bus.din;
            end
        end
    end

    // Same element is rewritten at least VECTOR_LEN cycles later, so no read/write bypass is needed
    bram_infer #(
        .ADDR_WIDTH(AW),
        .DATA_WIDTH(LANES * LW)
    ) u_ram (
        .clk     (clk),
        .i_we    (r1_valid),
        .i_waddr (r1_addr),
        .i_wdata (w_wr),
        .i_raddr (w_addr),
        .o_rdata (w_rd)
    );

    for (genvar i = 0; i < LANES; i++) begin : g_lane
        sat_add_lane #(
            .DIN_WIDTH  (DIN_WIDTH),
            .DOUT_WIDTH (DOUT_WIDTH),
            .SATURATE   (SATURATE)
        ) u_lane (
            .i_first (r1_first),
            .i_acc   (w_rd[i*LW +: DOUT_WIDTH]),
            .i_ovf   (w_rd[i*LW + DOUT_WIDTH]),
            .i_din   (r1_din[i*DIN_WIDTH +: DIN_WIDTH]),
            .o_sum   (w_sum[i*DOUT_WIDTH +: DOUT_WIDTH]),
            .o_ovf   (w_ovf[i])
        );
        assign w_wr[i*LW +: LW] = {w_ovf[i], w_sum[i*DOUT_WIDTH +: DOUT_WIDTH]};
    end

    // Stage 2: keep only results from the final frame of an accumulation
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r2_valid <= 1'b0;
            r2_last  <= 1'b0;
            r2_sum   <= '0;
            r2_ovf   <= '0;
        end else begin
            r2_valid <= r1_valid & r1_out;
            if (r1_valid) begin
                r2_last <= r1_last;
                r2_sum  <= w_sum;
                r2_ovf  <= w_ovf;
            end
        end
    end

    // Output register; dout/dout_ovf hold their last completed value between strobes
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.dout       <= '0;
            bus.dout_valid <= 1'b0;
            bus.dout_last  <= 1'b0;
            bus.dout_ovf   <= '0;
        end else begin
            bus.dout_valid <= r2_valid;
            bus.dout_last  <= r2_valid & r2_last;
            if (r2_valid) begin
                bus.dout     <= r2_sum;
                bus.dout_ovf <= r2_ovf;
            end
        end
    end
endmodule

// File: tb/tb_parallel_vector_acc.sv
// tb_parallel_vector_acc: scoreboard bench driving three accumulator configurations with one stream
module tb_parallel_vector_acc;
    localparam int L   = 2;
    localparam int VL  = 8;
    localparam int IW  = 16;
    localparam int DW0 = 24;
    localparam int DW1 = 17;
    localparam int ALW = 16;
    localparam int W [3] = '{24, 17, 17};
    localparam bit S [3] = '{1'b1, 1'b1, 1'b0};

    typedef struct packed {
        int               cyc;
        logic             last;
        logic [5:0]       o;
        logic [5:0][31:0] s;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic sync, din_valid;
    logic [ALW-1:0] acc_len;
    logic [L*IW-1:0] din;
    int cyc = 0;
    int n_tests = 0;
    int n_fail = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    parallel_vector_acc_if #(.DIN_WIDTH(IW), .DOUT_WIDTH(DW0), .LANES(L), .ACC_LEN_WIDTH(ALW)) b0 ();
    parallel_vector_acc_if #(.DIN_WIDTH(IW), .DOUT_WIDTH(DW1), .LANES(L), .ACC_LEN_WIDTH(ALW)) b1 ();
    parallel_vector_acc_if #(.DIN_WIDTH(IW), .DOUT_WIDTH(DW1), .LANES(L), .ACC_LEN_WIDTH(ALW)) b2 ();

    assign b0.sync = sync;   assign b0.din_valid = din_valid; assign b0.acc_len = acc_len; assign b0.din = din;
    assign b1.sync = sync;   assign b1.din_valid = din_valid; assign b1.acc_len = acc_len; assign b1.din = din;
    assign b2.sync = sync;   assign b2.din_valid = din_valid; assign b2.acc_len = acc_len; assign b2.din = din;

    parallel_vector_acc #(.DIN_WIDTH(IW), .DOUT_WIDTH(DW0), .LANES(L), .VECTOR_LEN(VL), .ACC_LEN_WIDTH(ALW), .SATURATE(1))
        dut0 (.clk(clk), .rst_n(rst_n), .bus(b0));
    parallel_vector_acc #(.DIN_WIDTH(IW), .DOUT_WIDTH(DW1), .LANES(L), .VECTOR_LEN(VL), .ACC_LEN_WIDTH(ALW), .SATURATE(1))
        dut1 (.clk(clk), .rst_n(rst_n), .bus(b1));
    parallel_vector_acc #(.DIN_WIDTH(IW), .DOUT_WIDTH(DW1), .LANES(L), .VECTOR_LEN(VL), .ACC_LEN_WIDTH(ALW), .SATURATE(0))
        dut2 (.clk(clk), .rst_n(rst_n), .bus(b2));

    logic [2:0] a_v, a_last;
    logic [1:0] a_ovf [3];
    logic signed [31:0] a_s [3][L];

    always_comb begin
        a_v    = {b2.dout_valid, b1.dout_valid, b0.dout_valid};
        a_last = {b2.dout_last, b1.dout_last, b0.dout_last};
        a_ovf[0] = b0.dout_ovf;
        a_ovf[1] = b1.dout_ovf;
        a_ovf[2] = b2.dout_ovf;
        for (int l = 0; l < L; l++) begin
            a_s[0][l] = 32'($signed(b0.dout[l*DW0 +: DW0]));
            a_s[1][l] = 32'($signed(b1.dout[l*DW1 +: DW1]));
            a_s[2][l] = 32'($signed(b2.dout[l*DW1 +: DW1]));
        end
    end

    // Reference model: per-element running sums as plain integers, one set per configuration
    longint m_sum [3][VL][L];
    bit     m_ovf [3][VL][L];
    bit     m_act = 1'b0;
    int     m_el, m_fr, m_len;
    exp_t   q [$];
    exp_t   m_e;

    task automatic chk(input string nm, input logic [127:0] a, input logic [127:0] x);
        n_tests++;
        if (a !== x) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", nm, a, x, cyc);
        end
    endtask

    task automatic chk_zero(input string nm);
        chk({nm, "_dut0"}, {b0.dout_valid, b0.dout_last, b0.dout_ovf, b0.dout}, '0);
        chk({nm, "_dut1"}, {b1.dout_valid, b1.dout_last, b1.dout_ovf, b1.dout}, '0);
        chk({nm, "_dut2"}, {b2.dout_valid, b2.dout_last, b2.dout_ovf, b2.dout}, '0);
    endtask

    function automatic longint lim(input int w);
        return longint'(1) <<< (w - 1);
    endfunction

    function automatic void sat_step(input longint a, input longint d, input int w, input bit sat,
                                     output longint r, output bit o);
        longint f;
        f = a + d;
        o = (f >= lim(w)) || (f < -lim(w));
        r = !o ? f : sat ? (f > 0 ? lim(w) - 1 : -lim(w)) : (f > 0 ? f - 2 * lim(w) : f + 2 * lim(w));
    endfunction

    function automatic int rnd16();
        logic [15:0] t;
        t = 16'($urandom);
        return int'($signed(t));
    endfunction

    task automatic model(input bit s, input int al, input longint d0, input longint d1);
        exp_t   e;
        longint d [2];
        longint r;
        bit     o, out;
        d[0] = d0;
        d[1] = d1;
        if (s) begin
            m_act = 1'b1;
            m_el  = 0;
            m_fr  = 0;
            m_len = (al == 0) ? 1 : al;
        end
        if (!m_act) return;
        out    = (m_fr == m_len - 1);
        e.cyc  = cyc + 2;
        e.last = (m_el == VL - 1);
        e.o    = '0;
        e.s    = '0;
        for (int k = 0; k < 3; k++) begin
            for (int l = 0; l < L; l++) begin
                sat_step((m_fr == 0) ? 64'sd0 : m_sum[k][m_el][l], d[l], W[k], S[k], r, o);
                m_ovf[k][m_el][l] = o | ((m_fr != 0) && m_ovf[k][m_el][l]);
                m_sum[k][m_el][l] = r;
                e.s[k*2+l] = 32'(r);
                e.o[k*2+l] = m_ovf[k][m_el][l];
            end
        end
        if (out) q.push_back(e);
        m_el++;
        if (m_el == VL) begin
            m_el = 0;
            if (out) begin
                m_fr  = 0;
                m_len = (al == 0) ? 1 : al;
            end else begin
                m_fr++;
            end
        end
    endtask

    // Monitor: pops one expectation per output strobe and flags anything missing or unexpected
    always @(negedge clk) begin
        while (q.size() > 0 && q[0].cyc < cyc) begin
            n_tests++;
            n_fail++;
            $display("FAIL missing_out: no dout_valid at cycle %0d (now %0d)", q[0].cyc, cyc);
            void'(q.pop_front());
        end
        if (a_v != 3'b000) begin
            if (q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL unexpected_out: dout_valid=%b at cycle %0d, expected none", a_v, cyc);
            end else begin
                m_e = q.pop_front();
                chk("latency", 128'(cyc), 128'(m_e.cyc));
                for (int k = 0; k < 3; k++)
                    chk($sformatf("dut%0d_out", k),
                        {a_v[k], a_last[k], a_ovf[k], a_s[k][1], a_s[k][0]},
                        {1'b1, m_e.last, m_e.o[k*2 +: 2], m_e.s[k*2+1], m_e.s[k*2]});
            end
        end
    end

    task automatic idle(input int n);
        din_valid = 1'b0;
        sync      = 1'b0;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send(input bit s, input int al, input int v0, input int v1, input int gap);
        repeat (gap) begin
            din_valid = 1'b0;
            sync      = 1'($urandom);
            din       = $urandom;
            acc_len   = 16'($urandom);
            @(posedge clk);
            #1;
        end
        din_valid = 1'b1;
        sync      = s;
        acc_len   = 16'(al);
        din       = {16'(v1), 16'(v0)};
        @(posedge clk);
        #1;
        model(s, al, longint'(v0), longint'(v1));
    endtask

    task automatic run_ramp(input int al, input int frames, input int maxgap);
        for (int f = 0; f < frames; f++)
            for (int k = 0; k < VL; k++)
                send(f == 0 && k == 0, al, k, -k, $urandom_range(maxgap, 0));
    endtask

    initial begin
        sync = 1'b0;
        din_valid = 1'b0;
        din = '0;
        acc_len = '0;
        repeat (3) @(posedge clk);
        #1;
        chk_zero("reset");
        rst_n = 1'b1;
        idle(2);
        // samples before any sync are ignored
        for (int k = 0; k < VL; k++) send(1'b0, 1, k + 1, -k - 1, 0);
        idle(4);
        // four-frame ramp, back to back
        run_ramp(4, 4, 0);
        idle(4);
        // acc_len=0 behaves as pass-through
        for (int i = 0; i < 3 * VL; i++) send(i == 0, 0, rnd16(), rnd16(), 0);
        idle(4);
        // overflow: three frames of full-scale values
        for (int i = 0; i < 3 * VL; i++) send(i == 0, 3, 32767, -32768, 0);
        idle(4);
        // ramp with random input gaps
        run_ramp(4, 4, 5);
        idle(4);
        // sync at element 5 of frame 2 aborts, then a fresh run
        run_ramp(4, 2, 0);
        for (int k = 0; k < 5; k++) send(1'b0, 4, k, -k, 0);
        run_ramp(4, 4, 0);
        idle(4);
        // long random stream: acc_len changing every sample, rare resyncs, small gaps
        for (int i = 0; i < 40 * VL; i++)
            send(i == 0 || $urandom_range(60, 0) == 0, $urandom_range(4, 0), rnd16(), rnd16(), $urandom_range(2, 0));
        idle(4);
        // asynchronous reset during frame 3
        run_ramp(4, 2, 0);
        for (int k = 0; k < 3; k++) send(1'b0, 4, k, -k, 0);
        rst_n = 1'b0;
        q.delete();
        m_act = 1'b0;
        #2;
        chk_zero("async_reset");
        idle(3);
        chk_zero("reset_hold");
        rst_n = 1'b1;
        idle(1);
        for (int i = 0; i < 2 * VL; i++) send(1'b0, 1, rnd16(), rnd16(), 0);
        idle(4);
        run_ramp(4, 4, 2);
        idle(6);
        chk("queue_drained", 128'(q.size()), 128'(0));
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/parallel_vector_acc.md
PARALLEL_VECTOR_ACC -- requirements
Module: parallel_vector_acc

Interface
REQ-001 SHALL have parameter DIN_WIDTH, default 16, signed input sample width per lane.
REQ-002 SHALL have parameter DOUT_WIDTH, default 32, signed accumulator/output width per lane; DOUT_WIDTH >= DIN_WIDTH.
REQ-003 SHALL have parameter LANES, default 4, number of parallel channels sharing one address stream.
REQ-004 SHALL have parameter VECTOR_LEN, default 64, vector length; power of two, >= 4.
REQ-005 SHALL have parameter ACC_LEN_WIDTH, default 16, width of the frame-count input.
REQ-006 SHALL have parameter SATURATE, default 1: 1 = clamp on overflow, 0 = two's-complement wrap.
REQ-007 SHALL have port clk  input  1  single clock, rising edge.
REQ-008 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-009 SHALL have port sync  input  1  frame start; qualified by din_valid; marks vector element 0.
REQ-010 SHALL have port acc_len  input  ACC_LEN_WIDTH  number of vectors per accumulation; 0 treated as 1.
REQ-011 SHALL have port din  input  LANES*DIN_WIDTH  signed samples; lane i at bits [i*DIN_WIDTH +: DIN_WIDTH].
REQ-012 SHALL have port din_valid  input  1  din/sync valid strobe.
REQ-013 SHALL have port dout  output  LANES*DOUT_WIDTH  accumulated sums, same lane packing.
REQ-014 SHALL have port dout_valid  output  1  dout holds a completed sum.
REQ-015 SHALL have port dout_last  output  1  with dout_valid on element VECTOR_LEN-1.
REQ-016 SHALL have port dout_ovf  output  LANES  per-lane sticky overflow for the element being output.

Function
REQ-017 SHALL run states IDLE, FIRST, ACC; din ignored in IDLE.
REQ-018 SHALL on sync&din_valid (any state) reset element address to 0, frame counter to 0, latch acc_len, enter FIRST; that sample is element 0.
REQ-019 SHALL in FIRST store din sign-extended (adds zero) and clear the element's ovf bit; in ACC add din to stored sum.
REQ-020 SHALL advance element address only on din_valid, wrapping at VECTOR_LEN-1; on wrap increment frame counter, FIRST->ACC.
REQ-021 SHALL treat the frame with counter == latched_len-1 as last; its sums drive dout; on its wrap restart at FIRST with acc_len re-latched (continuous operation, no sync needed).
REQ-022 SHALL with latched_len == 1 output every frame as pass-through (sign-extended din).
REQ-023 SHALL have fixed latency: sample accepted at cycle t -> dout_valid at t+2; din_valid gaps of any length allowed, no back-pressure.
REQ-024 SHALL sync mid-frame abort the accumulation: no dout for partial data.
REQ-025 SHALL per add, with SATURATE=1, clamp to +/-(2^(DOUT_WIDTH-1)) limits and set ovf bit; SATURATE=0 wrap and set ovf bit; ovf bit stored with sum.
REQ-026 SHALL keep state constant when acc_len changes mid-accumulation; new value takes effect at next latch point.
REQ-027 SHALL store sums in one inferred simple dual-port RAM, VECTOR_LEN x LANES*(DOUT_WIDTH+1), 1-cycle read; read-after-write safe because same-address distance >= VECTOR_LEN.

Reset
REQ-028 SHALL on rst_n low asynchronously force IDLE, address/frame counters 0, dout 0, dout_valid 0, dout_last 0, dout_ovf 0, pipeline valids 0.
REQ-029 SHALL not clear RAM contents; FIRST overwrite makes this safe.
REQ-030 SHALL after reset release wait in IDLE for sync.

Structure
REQ-031 SHALL place state encoding and saturating-add limit constants in shared package vacc_pkg.
REQ-032 SHALL instantiate one per-lane sub-module sat_add_lane (add, clamp, ovf), LANES copies; RAM via existing bram_infer.

Verification (LANES=2, VECTOR_LEN=8, DIN_WIDTH=16, DOUT_WIDTH=24 unless stated)
REQ-033 SHALL cover: acc_len=4, lane0=k, lane1=-k for element k, 4 frames continuous -> 8 dout_valid, lane0=4k, lane1=-4k, dout_last at k=7, ovf=0.
REQ-034 SHALL cover: acc_len=0 -> every frame output unchanged, sign-extended, 2 cycles after input.
REQ-035 SHALL cover: DOUT_WIDTH=17, SATURATE=1, acc_len=3, lane0=32767, lane1=-32768 -> lane0=65535, lane1=-65536, dout_ovf=2'b11; SATURATE=0 -> wrapped values, ovf=2'b11.
REQ-036 SHALL cover: case REQ-033 with random din_valid gaps (0-5 cycles) -> identical dout sequence.
REQ-037 SHALL cover: sync at element 5 of frame 2 -> no dout from aborted run; next output after 4 fresh frames, correct sums.
REQ-038 SHALL cover: rst_n low during frame 3 -> all outputs 0 immediately; data without sync ignored; post-sync results correct.
